impix_system_pio_led_ctrl: RTL and testbench
============================================

// Module: impix_system_pio_led_ctrl
// PURPOSE
//  Parametrised Avalon-MM output PIO for indicator LEDs, next generation of the 4-bit output PIO.
//  Adds atomic set/clear write ports and per-bit hardware blink driven by a programmable prescaler.
//  Sits on the system interconnect as a zero-wait-state slave; out_port drives board LEDs directly.
// PARAMETERS
//  DATA_WIDTH      4    number of output bits, legal 1..32
//  RESET_VALUE     0    DATA register value after reset (DATA_WIDTH bits)
//  PRESCALE_WIDTH  24   width of PERIOD register and blink counter, legal 1..32
//  RESET_PERIOD    0    PERIOD value after reset (0 = blink disabled)
// PORTS
//  clk         in   1               system clock, all logic rising-edge
//  reset       in   1               asynchronous, active-high reset
//  address     in   3               word address
//  chipselect  in   1               slave select
//  write_n     in   1               active-low write strobe, valid with chipselect
//  writedata   in   32              write data; bits above register width ignored
//  readdata    out  32              read data, combinational, zero-extended
//  out_port    out  DATA_WIDTH      LED outputs
// BEHAVIOUR
//  Register map (wr = chipselect & ~write_n):
//   0 DATA     R/W  wr: DATA <= writedata[DATA_WIDTH-1:0]
//   1 MASK     R/W  blink enable per bit
//   2 PERIOD   R/W  half-period in clk cycles; wr also forces cnt<=0, phase<=1
//   3 STATUS   R    bit0 = phase; bits[31:1]=0; writes ignored
//   4 OUTSET   W    wr: DATA <= DATA | writedata; reads 0
//   5 OUTCLEAR W    wr: DATA <= DATA & ~writedata; reads 0
//   6,7        -    reserved: reads 0, writes ignored
//  Reset (async, immediate): DATA=RESET_VALUE, MASK=0, PERIOD=RESET_PERIOD, cnt=0, phase=1;
//   hence out_port=RESET_VALUE; readdata follows address combinationally (no reset state).
//  Read: readdata = selected register, same cycle, no wait states; chipselect not required.
//  Write: registers update on the clk edge of the write; out_port reflects it the next cycle.
//  out_port = DATA & (~MASK | {DATA_WIDTH{phase}}) -- combinational from registers, glitch-free
//   per bit since all sources are flops.
//  Blink counter cnt[PRESCALE_WIDTH-1:0], every clk:
//   - write to PERIOD: cnt<=0, phase<=1 (overrides all below)
//   - else PERIOD==0: cnt<=0, phase<=1 (masked bits show DATA steady)
//   - else cnt>=PERIOD-1: cnt<=0, phase<=~phase
//   - else cnt<=cnt+1
//   => phase toggles every PERIOD cycles; PERIOD=1 toggles every clk.
//  Writes to DATA/MASK/OUTSET/OUTCLEAR do not disturb cnt or phase.
//  OUTSET/OUTCLEAR are single-cycle read-modify-write; no lost updates versus blink logic.
//  Reset asserted mid-blink: all state returns to reset values immediately; counting restarts
//   from 0 on first clk after deassertion.
// TESTING
//  T1 reset: RESET_VALUE=4'hA, assert reset -> out_port=4'hA, read addr 1/2/3 = 0/0/1.
//  T2 set/clear: write DATA=4'h3, OUTSET=4'h8, OUTCLEAR=4'h1 -> out_port 4'h3, 4'hB, 4'hA
//     each one cycle after its write; read addr 0 = 0xA; read addr 4/5 = 0.
//  T3 blink: DATA=4'hF, MASK=4'h1, PERIOD=3 -> bit0 low 3 clk, high 3 clk repeating,
//     bits[3:1] steady 1; STATUS bit0 tracks bit0 of out_port.
//  T4 period 0 / rewrite: mid-blink write PERIOD=0 -> out_port=4'hF next cycle, stays;
//     write PERIOD=2 -> phase=1 for 2 clk, then toggles every 2 clk.
//  T5 reset mid-operation: reset during phase=0 with PERIOD=5 -> out_port=RESET_VALUE
//     asynchronously, MASK=0, PERIOD=RESET_PERIOD.
//  T6 width: DATA_WIDTH=32, write 0xFFFF_FFFF to DATA, reserved addr 6 -> readdata 0,
//     DATA unchanged; DATA_WIDTH=1 upper writedata bits ignored.

Source files
------------

// File: rtl/impix_system_pio_led_ctrl.sv
// impix_system_pio_led_ctrl
// Avalon-MM output PIO for indicator LEDs. It provides a DATA register,
// atomic set and clear write ports, and per-bit hardware blink. The blink
// phase comes from a programmable half-period prescaler. The slave is
// zero-wait-state, and out_port drives the board LEDs directly from flops.
module impix_system_pio_led_ctrl #(
  parameter int unsigned               DATA_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE    = '0,
  parameter int unsigned               PRESCALE_WIDTH = 24,
  parameter logic [PRESCALE_WIDTH-1:0] RESET_PERIOD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [PRESCALE_WIDTH-1:0] PERIOD_ONE = PRESCALE_WIDTH'(1);

  logic [DATA_WIDTH-1:0]     data_q;
  logic [DATA_WIDTH-1:0]     mask_q;
  logic [PRESCALE_WIDTH-1:0] period_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic                      phase_q;

  logic                      wr;
  logic                      wr_period;
  logic [DATA_WIDTH-1:0]     wdata_d;
  logic [PRESCALE_WIDTH-1:0] wdata_p;
  logic [PRESCALE_WIDTH-1:0] period_last;
  logic                      unused_wdata;

  assign wr          = chipselect & ~write_n;
  assign wr_period   = wr && (address == ADDR_PERIOD);
  assign wdata_d     = writedata[DATA_WIDTH-1:0];
  assign wdata_p     = writedata[PRESCALE_WIDTH-1:0];
  assign period_last = period_q - PERIOD_ONE;

  // The bits of writedata above the register widths are deliberately dropped.
  assign unused_wdata = ^writedata;

  // DATA register: plain write, atomic OR-set, and AND-NOT-clear.
  // NOTE: clocked state uses non-blocking (<=) assignments, so every flop
  // samples the values from before the edge, even when one reads another.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data_q <= wdata_d;
        ADDR_OUTSET:   data_q <= data_q | wdata_d;
        ADDR_OUTCLEAR: data_q <= data_q & ~wdata_d;
        default:       ;
      endcase
    end
  end

  // MASK and PERIOD configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      period_q <= RESET_PERIOD;
    end else if (wr) begin
      if (address == ADDR_MASK)   mask_q   <= wdata_d;
      if (address == ADDR_PERIOD) period_q <= wdata_p;
    end
  end

  // Blink prescaler. The phase toggles once every PERIOD cycles. Writing
  // PERIOD, or a PERIOD of zero, parks the phase at 1 with the counter cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (wr_period || (period_q == '0)) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q >= period_last) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + PERIOD_ONE;
    end
  end

  // Combinational read mux. Results are zero-extended, and unreadable addresses return 0.
  // NOTE: readdata gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0]     = data_q;
      ADDR_MASK:   readdata[DATA_WIDTH-1:0]     = mask_q;
      ADDR_PERIOD: readdata[PRESCALE_WIDTH-1:0] = period_q;
      ADDR_STATUS: readdata[0]                  = phase_q;
      default:     ;
    endcase
  end

  // Masked bits follow the blink phase, and unmasked bits show DATA steadily.
  assign out_port = data_q & (~mask_q | {DATA_WIDTH{phase_q}});

endmodule

// File: tb/tb_impix_system_pio_led_ctrl.sv
// Directed testbench for impix_system_pio_led_ctrl.
// It uses a 4-bit instance (RESET_VALUE=4'hA), a 32-bit instance and a 1-bit instance.
module tb_impix_system_pio_led_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  logic [2:0]  address32;
  logic        chipselect32;
  logic        write_n32;
  logic [31:0] writedata32;
  logic [31:0] readdata32;
  logic [31:0] out_port32;

  logic [2:0]  address1;
  logic        chipselect1;
  logic        write_n1;
  logic [31:0] writedata1;
  logic [31:0] readdata1;
  logic [0:0]  out_port1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  impix_system_pio_led_ctrl #(
    .DATA_WIDTH(4), .RESET_VALUE(4'hA), .PRESCALE_WIDTH(24), .RESET_PERIOD(24'd0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  impix_system_pio_led_ctrl #(
    .DATA_WIDTH(32), .RESET_VALUE(32'h0), .PRESCALE_WIDTH(24), .RESET_PERIOD(24'd0)
  ) dut32 (
    .clk(clk), .reset(reset), .address(address32), .chipselect(chipselect32),
    .write_n(write_n32), .writedata(writedata32), .readdata(readdata32), .out_port(out_port32)
  );

  impix_system_pio_led_ctrl #(
    .DATA_WIDTH(1), .RESET_VALUE(1'b0), .PRESCALE_WIDTH(24), .RESET_PERIOD(24'd0)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address1), .chipselect(chipselect1),
    .write_n(write_n1), .writedata(writedata1), .readdata(readdata1), .out_port(out_port1)
  );

  // Single-cycle write. Call it at a negedge. It returns at the next negedge,
  // which is the first cycle in which the write is visible.
  task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] d);
    case (sel)
      0: begin address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; end
      1: begin address32 = a; writedata32 = d; chipselect32 = 1'b1; write_n32 = 1'b0; end
      default: begin address1 = a; writedata1 = d; chipselect1 = 1'b1; write_n1 = 1'b0; end
    endcase
    @(negedge clk);
    chipselect = 1'b0;   write_n = 1'b1;
    chipselect32 = 1'b0; write_n32 = 1'b1;
    chipselect1 = 1'b0;  write_n1 = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [8];
    exp_rd = '{32'hA, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    #1;
    n_checks++;
    if (out_port !== 4'hA) begin
      n_fail++; $display("FAIL reset_out_port: got %h want %h", out_port, 4'hA);
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      n_checks++;
      if (readdata !== exp_rd[a]) begin
        n_fail++; $display("FAIL reset_read_addr%0d: got %h want %h", a, readdata, exp_rd[a]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_clear();
    bus_write(0, 3'd0, 32'h3);
    n_checks++;
    if (out_port !== 4'h3) begin
      n_fail++; $display("FAIL data_write: got %h want %h", out_port, 4'h3);
    end
    bus_write(0, 3'd4, 32'h8);
    n_checks++;
    if (out_port !== 4'hB) begin
      n_fail++; $display("FAIL outset: got %h want %h", out_port, 4'hB);
    end
    bus_write(0, 3'd5, 32'h1);
    n_checks++;
    if (out_port !== 4'hA) begin
      n_fail++; $display("FAIL outclear: got %h want %h", out_port, 4'hA);
    end
    bus_write(0, 3'd7, 32'hF);
    address = 3'd0; #1;
    n_checks++;
    if (readdata !== 32'hA) begin
      n_fail++; $display("FAIL read_data_after_reserved_wr: got %h want %h", readdata, 32'hA);
    end
    address = 3'd4; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL read_outset: got %h want 0", readdata);
    end
    address = 3'd5; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL read_outclear: got %h want 0", readdata);
    end
    @(negedge clk);
  endtask

  task automatic test_blink();
    logic exp_ph;
    bus_write(0, 3'd0, 32'hF);
    bus_write(0, 3'd1, 32'h1);
    address = 3'd2; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL period_before: got %h want 0", readdata);
    end
    @(negedge clk);
    bus_write(0, 3'd2, 32'd3);
    address = 3'd3;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_ph = ((i / 3) % 2) == 0;
      n_checks++;
      if (out_port !== {3'b111, exp_ph}) begin
        n_fail++; $display("FAIL blink3_out idx%0d: got %h want %h", i, out_port, {3'b111, exp_ph});
      end
      n_checks++;
      if (readdata !== {31'h0, exp_ph}) begin
        n_fail++; $display("FAIL blink3_status idx%0d: got %h want %h", i, readdata, exp_ph);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_period_rewrite();
    logic exp_ph;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_port !== 4'hE) begin
      n_fail++; $display("FAIL midblink_low: got %h want %h", out_port, 4'hE);
    end
    bus_write(0, 3'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_port !== 4'hF) begin
        n_fail++; $display("FAIL period0_steady idx%0d: got %h want %h", i, out_port, 4'hF);
      end
      @(negedge clk);
    end
    bus_write(0, 3'd2, 32'd2);
    for (int i = 0; i < 8; i++) begin
      exp_ph = ((i / 2) % 2) == 0;
      n_checks++;
      if (out_port !== {3'b111, exp_ph}) begin
        n_fail++; $display("FAIL blink2_out idx%0d: got %h want %h", i, out_port, {3'b111, exp_ph});
      end
      @(negedge clk);
    end
    // A clear during blinking must leave the phase sequence untouched.
    bus_write(0, 3'd5, 32'h8);
    n_checks++;
    if (out_port !== 4'h7) begin
      n_fail++; $display("FAIL clear_during_blink idx9: got %h want %h", out_port, 4'h7);
    end
    @(negedge clk);
    n_checks++;
    if (out_port !== 4'h6) begin
      n_fail++; $display("FAIL clear_during_blink idx10: got %h want %h", out_port, 4'h6);
    end
  endtask

  task automatic test_reset_mid_blink();
    bus_write(0, 3'd2, 32'd5);
    repeat (5) @(negedge clk);
    n_checks++;
    if (out_port !== 4'h6) begin
      n_fail++; $display("FAIL period5_low_before_reset: got %h want %h", out_port, 4'h6);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_port !== 4'hA) begin
      n_fail++; $display("FAIL async_reset_out: got %h want %h", out_port, 4'hA);
    end
    address = 3'd1; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mask: got %h want 0", readdata);
    end
    address = 3'd2; #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_period: got %h want 0", readdata);
    end
    address = 3'd3; #1;
    n_checks++;
    if (readdata !== 32'h1) begin
      n_fail++; $display("FAIL reset_phase: got %h want 1", readdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_width();
    bus_write(1, 3'd0, 32'hFFFF_FFFF);
    n_checks++;
    if (out_port32 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL w32_out: got %h want %h", out_port32, 32'hFFFF_FFFF);
    end
    bus_write(1, 3'd6, 32'h0);
    address32 = 3'd6; #1;
    n_checks++;
    if (readdata32 !== 32'h0) begin
      n_fail++; $display("FAIL w32_reserved_read: got %h want 0", readdata32);
    end
    address32 = 3'd0; #1;
    n_checks++;
    if (readdata32 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL w32_data_unchanged: got %h want %h", readdata32, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    bus_write(1, 3'd5, 32'h8000_0001);
    n_checks++;
    if (out_port32 !== 32'h7FFF_FFFE) begin
      n_fail++; $display("FAIL w32_outclear: got %h want %h", out_port32, 32'h7FFF_FFFE);
    end
    bus_write(2, 3'd0, 32'hFFFF_FFFE);
    address1 = 3'd0; #1;
    n_checks++;
    if (out_port1 !== 1'b0 || readdata1 !== 32'h0) begin
      n_fail++; $display("FAIL w1_upper_ignored: got out %h rd %h want 0/0", out_port1, readdata1);
    end
    @(negedge clk);
    bus_write(2, 3'd0, 32'h0000_0003);
    #1;
    n_checks++;
    if (out_port1 !== 1'b1 || readdata1 !== 32'h1) begin
      n_fail++; $display("FAIL w1_write: got out %h rd %h want 1/1", out_port1, readdata1);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    address = 3'd0;   chipselect = 1'b0;   write_n = 1'b1;   writedata = '0;
    address32 = 3'd0; chipselect32 = 1'b0; write_n32 = 1'b1; writedata32 = '0;
    address1 = 3'd0;  chipselect1 = 1'b0;  write_n1 = 1'b1;  writedata1 = '0;
    test_reset();
    test_set_clear();
    test_blink();
    test_period_rewrite();
    test_reset_mid_blink();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
